uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter MAX_LEN, 16: maximum payload bytes per frame, 1..255.
REQ-002 Parameter TIMEOUT_CLKS, 100000: maximum clocks allowed between bytes inside one frame.
REQ-003 i_Clock  in  1  single clock; all logic on its rising edge.
REQ-004 i_Reset  in  1  reset, synchronous and active-high.
REQ-005 i_Rx_DV  in  1  one-cycle strobe; receive byte valid.
REQ-006 i_Rx_Byte  in  8  received byte, sampled only when i_Rx_DV=1.
REQ-007 i_Core_Ready  in  1  crypto core accepts a command.
REQ-008 i_Core_Done  in  1  one-cycle strobe; core finished the current command.
REQ-009 o_Wr_En  out  1  one-cycle payload write strobe.
REQ-010 o_Wr_Addr  out  8  payload byte index, 0..LEN-1.
REQ-011 o_Wr_Data  out  8  payload byte.
REQ-012 o_Cmd_Valid  out  1  command pending to core.
REQ-013 o_Cmd_Op  out  8  opcode of the pending command.
REQ-014 o_Cmd_Len  out  8  payload length of the pending command.
REQ-015 o_Busy  out  1  high in every state except IDLE.
REQ-016 o_Err  out  3  sticky error flags: [0] bad length, [1] timeout, [2] checksum or overrun.

Function
REQ-017 Frame format: SYNC byte 0xA5, OP, LEN, LEN payload bytes, then CKSUM when the configuration macro is defined.
REQ-018 State machine states: IDLE, GET_OP, GET_LEN, PAYLOAD, CKSUM, ISSUE, WAIT_DONE.
REQ-019 IDLE: byte 0xA5 moves to GET_OP; any other byte is discarded silently.
REQ-020 GET_OP: the byte is latched into o_Cmd_Op, then the block moves to GET_LEN.
REQ-021 GET_LEN: LEN=0 or LEN>MAX_LEN sets o_Err[0] and returns to IDLE; otherwise the byte is latched into o_Cmd_Len and the block moves to PAYLOAD.
REQ-022 PAYLOAD: each byte drives o_Wr_En=1 for one cycle, on the cycle after its i_Rx_DV, with o_Wr_Addr equal to the byte index, then the index increments.
REQ-023 After byte LEN-1 the block moves to CKSUM if the macro is defined, else to ISSUE.
REQ-024 ISSUE: o_Cmd_Valid=1 is held; the handshake completes on a cycle where o_Cmd_Valid and i_Core_Ready are both high, then the block moves to WAIT_DONE with o_Cmd_Valid=0 on the next cycle.
REQ-025 WAIT_DONE: i_Core_Done returns the block to IDLE; i_Core_Done is ignored in every other state.
REQ-026 A byte arriving in ISSUE or WAIT_DONE is dropped, sets o_Err[2], and changes no state.
REQ-027 Inter-byte timer: cleared on every i_Rx_DV; counts in GET_OP, GET_LEN, PAYLOAD and CKSUM only.
REQ-028 When the timer reaches TIMEOUT_CLKS-1, o_Err[1] sets and the block returns to IDLE with no command issued.
REQ-029 If a byte and a timeout coincide, the byte wins and the timer clears.
REQ-030 o_Err bits are cleared only by reset or by a valid SYNC byte received in IDLE; the same-cycle error sets take priority over the clear.
REQ-031 Payload bytes already written before an abort are not retracted; the consumer gates on o_Cmd_Valid.

Reset
REQ-032 During i_Reset=1: state=IDLE; all outputs 0; timer and byte index cleared.
REQ-033 Reset mid-frame or mid-command drops the frame, and inputs are ignored on that cycle.

Configuration
REQ-034 Macro UART_CMD_CKSUM_EN defined: CKSUM is the XOR of OP, LEN and all payload bytes; a mismatch sets o_Err[2] and returns to IDLE; a match moves to ISSUE.
REQ-035 Macro undefined: the CKSUM state and the XOR accumulator are absent, and PAYLOAD goes directly to ISSUE.

Structure
REQ-036 Package uart_cmd_pkg holds the state enum, SYNC_BYTE=8'hA5, and the error-bit index constants.
REQ-037 Sub-module uart_cmd_timer implements the inter-byte timeout counter: inputs clear and enable, output expire.
REQ-038 The block connects directly to the UART receiver's data-valid and byte outputs, with no added buffering.

Verification
REQ-039 Frame A5 03 02 11 22 (+ CKSUM 32 when enabled) -> writes (0,11),(1,22); o_Cmd_Valid with Op=03, Len=02; i_Core_Ready asserted 3 cycles later completes the handshake.
REQ-040 Frame A5 01 00 -> o_Err[0]=1, no write, back in IDLE; a subsequent valid frame completes normally and clears o_Err.
REQ-041 A5 01 04 AA followed by silence for TIMEOUT_CLKS -> o_Err[1]=1, IDLE, o_Cmd_Valid never asserted.
REQ-042 With the macro enabled, A5 02 01 55 00 -> o_Err[2]=1, no command issued.
REQ-043 Byte 0x5A sent during WAIT_DONE -> o_Err[2]=1, state unchanged; i_Core_Done then returns to IDLE.
REQ-044 i_Reset pulsed after payload byte 1 of 4 -> all outputs 0; the next full frame is processed correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// The CKSUM state exists only when UART_CMD_CKSUM_EN is defined.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_LEN,
    PAYLOAD,
`ifdef UART_CMD_CKSUM_EN
    CKSUM,
`endif
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int ERR_LEN     = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_OVERRUN = 2;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: cleared by every received byte, counts while enabled,
// and flags expiry on the cycle it sits at TIMEOUT_CLKS-1.
module uart_cmd_timer #(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count;

  assign expire = enable && (count == LAST);

  // Saturates at LAST so an expired timer never wraps back into range.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser between a UART receiver and a crypto core: SYNC, OP, LEN, payload,
// optional XOR checksum (UART_CMD_CKSUM_EN), then a ready/valid command handoff.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Core_Ready,
  input  logic       i_Core_Done,
  output logic       o_Wr_En,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd_Op,
  output logic [7:0] o_Cmd_Len,
  output logic       o_Busy,
  output logic [2:0] o_Err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state, state_next;
  logic [7:0] idx;
  logic       latch_op, latch_len, wr_fire, err_clr;
  logic [2:0] err_set;
  logic       tmr_en, tmr_expire;
`ifdef UART_CMD_CKSUM_EN
  logic [7:0] acc;
`endif

  assign tmr_en = (state == GET_OP) || (state == GET_LEN) || (state == PAYLOAD)
`ifdef UART_CMD_CKSUM_EN
                  || (state == CKSUM)
`endif
                  ;

  uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk    (i_Clock),
    .rst    (i_Reset),
    .clear  (i_Rx_DV),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  // A byte always wins over a coincident timeout in the timed states.
  always_comb begin
    state_next = state;
    latch_op   = 1'b0;
    latch_len  = 1'b0;
    wr_fire    = 1'b0;
    err_clr    = 1'b0;
    err_set    = '0;
    unique case (state)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          err_clr    = 1'b1;
          state_next = GET_OP;
        end
      end
      GET_OP: begin
        if (i_Rx_DV) begin
          latch_op   = 1'b1;
          state_next = GET_LEN;
        end else if (tmr_expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = IDLE;
        end
      end
      GET_LEN: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
            err_set[ERR_LEN] = 1'b1;
            state_next       = IDLE;
          end else begin
            latch_len  = 1'b1;
            state_next = PAYLOAD;
          end
        end else if (tmr_expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = IDLE;
        end
      end
      PAYLOAD: begin
        if (i_Rx_DV) begin
          wr_fire = 1'b1;
          if (idx == (o_Cmd_Len - 8'd1)) begin
`ifdef UART_CMD_CKSUM_EN
            state_next = CKSUM;
`else
            state_next = ISSUE;
`endif
          end
        end else if (tmr_expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = IDLE;
        end
      end
`ifdef UART_CMD_CKSUM_EN
      CKSUM: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == acc) begin
            state_next = ISSUE;
          end else begin
            err_set[ERR_OVERRUN] = 1'b1;
            state_next           = IDLE;
          end
        end else if (tmr_expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = IDLE;
        end
      end
`endif
      ISSUE: begin
        err_set[ERR_OVERRUN] = i_Rx_DV;
        if (i_Core_Ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        err_set[ERR_OVERRUN] = i_Rx_DV;
        if (i_Core_Done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Wr_En   <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      o_Cmd_Op  <= '0;
      o_Cmd_Len <= '0;
      o_Err     <= '0;
      idx       <= '0;
    end else begin
      o_Wr_En <= wr_fire;
      if (latch_op) o_Cmd_Op <= i_Rx_Byte;
      if (latch_len) begin
        o_Cmd_Len <= i_Rx_Byte;
        idx       <= '0;
      end
      if (wr_fire) begin
        o_Wr_Addr <= idx;
        o_Wr_Data <= i_Rx_Byte;
        idx       <= idx + 8'd1;
      end
      o_Err <= (err_clr ? 3'b000 : o_Err) | err_set;
    end
  end

`ifdef UART_CMD_CKSUM_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset)                  acc <= '0;
    else if (latch_op)            acc <= i_Rx_Byte;
    else if (latch_len || wr_fire) acc <= acc ^ i_Rx_Byte;
  end
`endif

  assign o_Cmd_Valid = (state == ISSUE);
  assign o_Busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl; frames carry a checksum byte when
// UART_CMD_CKSUM_EN is defined.
module tb_uart_cmd_ctrl;

  localparam int MAX_LEN = 4;
  localparam int TO      = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       core_ready = 1'b0;
  logic       core_done = 1'b0;
  logic       wr_en, cmd_valid, busy;
  logic [7:0] wr_addr, wr_data, cmd_op, cmd_len;
  logic [2:0] err;

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Core_Ready (core_ready),
    .i_Core_Done  (core_done),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Cmd_Valid  (cmd_valid),
    .o_Cmd_Op     (cmd_op),
    .o_Cmd_Len    (cmd_len),
    .o_Busy       (busy),
    .o_Err        (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] exp_cmd[$];
  bit          saw_valid = 1'b0;

  // Every payload write the DUT makes must match the head of the write queue.
  always @(negedge clk) begin : wr_monitor
    logic [15:0] e;
    if (cmd_valid) saw_valid = 1'b1;
    if (wr_en) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e)
          $display("FAIL wr_data: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   wr_addr, wr_data, e[15:8], e[7:0]);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] len, input logic [7:0] base);
    logic [7:0] d;
`ifdef UART_CMD_CKSUM_EN
    logic [7:0] ck;
    ck = op ^ len;
`endif
    send_byte(8'hA5);
    send_byte(op);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      d = base + 8'(i) * 8'h11;
`ifdef UART_CMD_CKSUM_EN
      ck ^= d;
`endif
      exp_wr.push_back({8'(i), d});
      send_byte(d);
    end
`ifdef UART_CMD_CKSUM_EN
    send_byte(ck);
`endif
    exp_cmd.push_back({op, len});
  endtask

  // Wait for the command, hold off ready, handshake, optionally overrun, then finish.
  task automatic run_cmd(input int ready_delay, input bit overrun);
    logic [15:0] e;
    int n;
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!cmd_valid) begin
      $display("FAIL cmd_valid_wait: o_Cmd_Valid=0 after %0d cycles, expected 1", n);
      return;
    end
    n_pass++;
    n_checks++;
    if (exp_cmd.size() == 0) begin
      $display("FAIL cmd_unexpected: got op=%0h len=%0h, expected no command", cmd_op, cmd_len);
    end else begin
      e = exp_cmd.pop_front();
      if ({cmd_op, cmd_len} !== e)
        $display("FAIL cmd_fields: got op=%0h len=%0h, expected op=%0h len=%0h",
                 cmd_op, cmd_len, e[15:8], e[7:0]);
      else n_pass++;
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    tick(ready_delay);
    n_checks++;
    if (cmd_valid !== 1'b1) $display("FAIL cmd_held: o_Cmd_Valid=%b, expected 1", cmd_valid);
    else n_pass++;
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++;
    if ({cmd_valid, busy} !== 2'b01)
      $display("FAIL handshake: valid=%b busy=%b, expected valid=0 busy=1", cmd_valid, busy);
    else n_pass++;
    if (overrun) begin
      send_byte(8'h5A);
      n_checks++;
      if ({err, busy} !== 4'b1001)
        $display("FAIL overrun: err=%b busy=%b, expected err=100 busy=1", err, busy);
      else n_pass++;
    end
    tick(2);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL done_idle: busy=%b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy, err} !== 38'd0)
      $display("FAIL reset_outputs: wr_en=%b addr=%0h data=%0h valid=%b op=%0h len=%0h busy=%b err=%b, expected all 0",
               wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy, err);
    else n_pass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    send_frame(8'h03, 8'h02, 8'h11);
    run_cmd(3, 1'b0);
    n_checks++;
    if (err !== 3'b000) $display("FAIL basic_err: err=%b, expected 000", err);
    else n_pass++;
  endtask

  task automatic test_bad_len;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    tick(1);
    n_checks++;
    if ({err, busy} !== 4'b0010) $display("FAIL len_zero: err=%b busy=%b, expected err=001 busy=0", err, busy);
    else n_pass++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'(MAX_LEN + 1));
    tick(1);
    n_checks++;
    if ({err, busy} !== 4'b0010) $display("FAIL len_over: err=%b busy=%b, expected err=001 busy=0", err, busy);
    else n_pass++;
    send_frame(8'h01, 8'(MAX_LEN), 8'h10);
    run_cmd(1, 1'b0);
    n_checks++;
    if (err !== 3'b000) $display("FAIL len_max_clear: err=%b, expected 000", err);
    else n_pass++;
  endtask

  task automatic test_timeout;
    saw_valid = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    exp_wr.push_back({8'h00, 8'hAA});
    send_byte(8'hAA);
    tick(TO + 2);
    n_checks++;
    if ({err, busy, saw_valid} !== 5'b01000)
      $display("FAIL timeout_abort: err=%b busy=%b saw_valid=%b, expected err=010 busy=0 saw_valid=0",
               err, busy, saw_valid);
    else n_pass++;
    send_byte(8'hA5); send_byte(8'h07);
    tick(TO - 2);
    send_byte(8'h03);
    n_checks++;
    if ({err, busy} !== 4'b0001)
      $display("FAIL timeout_edge_byte: err=%b busy=%b, expected err=000 busy=1", err, busy);
    else n_pass++;
    tick(TO + 2);
    n_checks++;
    if ({err, busy, saw_valid} !== 5'b01000)
      $display("FAIL timeout_payload: err=%b busy=%b saw_valid=%b, expected err=010 busy=0 saw_valid=0",
               err, busy, saw_valid);
    else n_pass++;
    send_byte(8'hA5); send_byte(8'h07);
    tick(TO - 1);
    send_byte(8'h03);
    n_checks++;
    if ({err, busy} !== 4'b0100)
      $display("FAIL timeout_late_byte: err=%b busy=%b, expected err=010 busy=0", err, busy);
    else n_pass++;
  endtask

  task automatic test_overrun;
    send_frame(8'h20, 8'h01, 8'h30);
    run_cmd(0, 1'b1);
    n_checks++;
    if (err !== 3'b100) $display("FAIL overrun_sticky: err=%b, expected 100", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    saw_valid = 1'b0;
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h04);
    exp_wr.push_back({8'h00, 8'hB1});
    send_byte(8'hB1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy, err, saw_valid} !== 39'd0)
      $display("FAIL reset_mid: wr_en=%b addr=%0h data=%0h valid=%b op=%0h len=%0h busy=%b err=%b, expected all 0",
               wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy, err);
    else n_pass++;
    rst = 1'b0;
    send_frame(8'h09, 8'h04, 8'h40);
    run_cmd(2, 1'b0);
  endtask

`ifdef UART_CMD_CKSUM_EN
  task automatic test_cksum;
    saw_valid = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    exp_wr.push_back({8'h00, 8'h55});
    send_byte(8'h55);
    send_byte(8'h00);
    tick(1);
    n_checks++;
    if ({err, busy, saw_valid} !== 5'b10000)
      $display("FAIL cksum_bad: err=%b busy=%b saw_valid=%b, expected err=100 busy=0 saw_valid=0",
               err, busy, saw_valid);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_bad_len;
    test_timeout;
    test_overrun;
    test_reset_mid;
`ifdef UART_CMD_CKSUM_EN
    test_cksum;
`endif
    tick(2);
    n_checks++;
    if (exp_wr.size() != 0 || exp_cmd.size() != 0)
      $display("FAIL scoreboard_drain: writes left=%0d cmds left=%0d, expected 0 and 0",
               exp_wr.size(), exp_cmd.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
